// File: rtl/ctc_int_ctrl.sv
// Z80 CTC interrupt controller: latches channel zero-count requests, arbitrates
// them with fixed priority, drives the IEI/IEO daisy chain and the mode-2 vector.
module ctc_int_ctrl #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CHW  = 2,
  parameter int unsigned DWID = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ce_n,
  input  logic            m1_n,
  input  logic            rd_n,
  input  logic            iorq_n,
  input  logic [CHW-1:0]  a,
  input  logic [DWID-1:0] din,
  input  logic [N_CH-1:0] irq,
  input  logic            iei,
  output logic            ieo,
  output logic            int_n,
  output logic [DWID-1:0] vec,
  output logic            vec_oe,
  output logic [N_CH-1:0] ack,
  output logic [N_CH-1:0] in_service
);

  localparam int unsigned VBW = DWID - CHW - 1;
  localparam logic [DWID-1:0] OP_ED = DWID'(8'hED);
  localparam logic [DWID-1:0] OP_4D = DWID'(8'h4D);

  typedef enum logic {RETI_IDLE, RETI_ED_SEEN} reti_e;

  reti_e           state_q, state_d;
  logic            wr_act_q, inta_act_q, fetch_act_q;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] ie_q, ie_d;
  logic [N_CH-1:0] insvc_q, insvc_d;
  logic [VBW-1:0]  base_q, base_d;
  logic            int_n_q, int_n_d;
  logic            ieo_q, ieo_d;
  logic [DWID-1:0] vec_q, vec_d;
  logic            vec_oe_q, vec_oe_d;
  logic [N_CH-1:0] ack_q, ack_d;

  logic            wr_act, inta_act, fetch_act;
  logic            wr_stb, inta_stb, fetch_stb;
  logic [N_CH-1:0] elig, grant, ack_set, reti_clr;
  logic [CHW-1:0]  k;
  logic            blk;

  assign wr_act    = ~ce_n & ~iorq_n & m1_n & rd_n;
  assign inta_act  = ~m1_n & ~iorq_n;
  assign fetch_act = ~m1_n & ~rd_n & iorq_n;
  assign wr_stb    = wr_act & ~wr_act_q;
  assign inta_stb  = inta_act & ~inta_act_q;
  assign fetch_stb = fetch_act & ~fetch_act_q;

  // A channel is blocked by its own in-service flag and by any higher-priority one.
  always_comb begin
    blk  = 1'b0;
    elig = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      blk     = blk | insvc_q[i];
      elig[i] = pend_q[i] & ie_q[i] & ~blk;
    end
  end

  assign grant = elig & (~elig + N_CH'(1));

  always_comb begin
    k = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant[i]) k = CHW'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    ie_d     = ie_q;
    base_d   = base_q;
    vec_d    = vec_q;
    vec_oe_d = vec_oe_q & inta_act;
    ack_set  = '0;
    reti_clr = '0;

    if (wr_stb) begin
      if (!din[0]) begin
        base_d = din[DWID-1:CHW+1];
      end else begin
        for (int unsigned i = 0; i < N_CH; i++) begin
          if (a == CHW'(i)) begin
            ie_d[i] = din[DWID-1];
            if (din[1]) pend_d[i] = 1'b0;
          end
        end
      end
    end

    if (inta_stb && iei && !int_n_q && (|elig)) begin
      vec_d    = {base_q, k, 1'b0};
      vec_oe_d = 1'b1;
      ack_set  = grant;
    end

    unique case (state_q)
      RETI_IDLE: begin
        if (fetch_stb && din == OP_ED) state_d = RETI_ED_SEEN;
      end
      RETI_ED_SEEN: begin
        if (fetch_stb) begin
          if (din == OP_4D) begin
            if (iei) reti_clr = insvc_q & (~insvc_q + N_CH'(1));
            state_d = RETI_IDLE;
          end else if (din != OP_ED) begin
            state_d = RETI_IDLE;
          end
        end
      end
      default: state_d = RETI_IDLE;
    endcase

    // New requests are applied last so a same-cycle set beats any clear.
    pend_d  = (pend_d & ~ack_set) | irq;
    insvc_d = (insvc_q | ack_set) & ~reti_clr;
    ack_d   = ack_set;
    int_n_d = ~(iei & (|elig));
    ieo_d   = iei & ~(|insvc_q) & ~(|(pend_q & ie_q));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RETI_IDLE;
      wr_act_q    <= 1'b0;
      inta_act_q  <= 1'b0;
      fetch_act_q <= 1'b0;
      pend_q      <= '0;
      ie_q        <= '0;
      insvc_q     <= '0;
      base_q      <= '0;
      int_n_q     <= 1'b1;
      ieo_q       <= 1'b0;
      vec_q       <= '0;
      vec_oe_q    <= 1'b0;
      ack_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_act_q    <= wr_act;
      inta_act_q  <= inta_act;
      fetch_act_q <= fetch_act;
      pend_q      <= pend_d;
      ie_q        <= ie_d;
      insvc_q     <= insvc_d;
      base_q      <= base_d;
      int_n_q     <= int_n_d;
      ieo_q       <= ieo_d;
      vec_q       <= vec_d;
      vec_oe_q    <= vec_oe_d;
      ack_q       <= ack_d;
    end
  end

  assign int_n      = int_n_q;
  assign ieo        = ieo_q;
  assign vec        = vec_q;
  assign vec_oe     = vec_oe_q;
  assign ack        = ack_q;
  assign in_service = insvc_q;

endmodule

// File: tb/tb_ctc_int_ctrl.sv
// Bench for ctc_int_ctrl: a step table of bus operations with expected
// int_n/ieo/in_service, a vector/ack scoreboard, and hand-written corner sequences.
module tb_ctc_int_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, ce_n, m1_n, rd_n, iorq_n, iei;
  logic [1:0] a;
  logic [7:0] din;
  logic [3:0] irq;
  logic       ieo, int_n, vec_oe;
  logic [7:0] vec;
  logic [3:0] ack, in_service;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ctc_int_ctrl #(.N_CH(4), .CHW(2), .DWID(8)) dut (
    .clk(clk), .reset_n(reset_n), .ce_n(ce_n), .m1_n(m1_n), .rd_n(rd_n),
    .iorq_n(iorq_n), .a(a), .din(din), .irq(irq), .iei(iei), .ieo(ieo),
    .int_n(int_n), .vec(vec), .vec_oe(vec_oe), .ack(ack), .in_service(in_service)
  );

  typedef struct packed {
    logic [7:0] vec;
    logic [3:0] ack;
  } sb_t;
  sb_t sb_q[$];

  typedef enum int {OP_WR, OP_IRQ, OP_INTA, OP_FETCH, OP_IEI} op_e;
  typedef struct {
    op_e        op;
    logic [3:0] arg;
    logic [7:0] data;
    logic       ackv;
    logic       exp_int_n;
    logic       exp_ieo;
    logic [3:0] exp_isv;
  } step_t;
  step_t steps[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every acknowledge the DUT produces must match the oldest expected vector.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && ack !== 4'b0000) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected: got ack=%b vec=%h expected no ack", ack, vec);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if (ack !== e.ack || vec !== e.vec || vec_oe !== 1'b1) begin
          errors++;
          $display("FAIL ack_vector: got ack=%b vec=%h oe=%b expected ack=%b vec=%h oe=1",
                   ack, vec, vec_oe, e.ack, e.vec);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] ch, input logic [7:0] d);
    ce_n = 1'b0; iorq_n = 1'b0; a = ch; din = d;
    tick; tick;
    ce_n = 1'b1; iorq_n = 1'b1;
    tick;
  endtask

  task automatic pulse_irq(input logic [3:0] m);
    irq = m;
    tick;
    irq = 4'b0000;
  endtask

  task automatic fetch(input logic [7:0] op);
    m1_n = 1'b0; rd_n = 1'b0; din = op;
    tick;
    m1_n = 1'b1; rd_n = 1'b1;
    tick;
  endtask

  task automatic inta(input logic expv, input logic [7:0] v, input logic [3:0] ackm,
                      input logic [3:0] irq_during);
    if (expv) sb_q.push_back('{vec: v, ack: ackm});
    m1_n = 1'b0; iorq_n = 1'b0; irq = irq_during;
    tick;
    irq = 4'b0000;
    chk("vec_oe_at_ack", 32'(vec_oe), 32'(expv));
    tick;
    chk("ack_one_cycle", 32'(ack), 32'(0));
    chk("vec_oe_hold", 32'(vec_oe), 32'(expv));
    m1_n = 1'b1; iorq_n = 1'b1;
    tick;
    chk("vec_oe_drop", 32'(vec_oe), 32'(0));
  endtask

  function automatic void add(input op_e op, input logic [3:0] arg, input logic [7:0] data,
                              input logic ackv, input logic intn, input logic ieov,
                              input logic [3:0] isv);
    step_t s;
    s.op = op; s.arg = arg; s.data = data; s.ackv = ackv;
    s.exp_int_n = intn; s.exp_ieo = ieov; s.exp_isv = isv;
    steps.push_back(s);
  endfunction

  initial begin
    // For OP_INTA: arg = expected ack mask, data = expected vector.
    add(OP_WR,    4'd0,    8'h40, 0, 1, 1, 4'b0000);
    add(OP_WR,    4'd2,    8'h81, 0, 1, 1, 4'b0000);
    add(OP_IRQ,   4'b0100, 8'h00, 0, 0, 0, 4'b0000);
    add(OP_INTA,  4'b0100, 8'h44, 1, 1, 0, 4'b0100);
    add(OP_FETCH, 4'd0,    8'hED, 0, 1, 0, 4'b0100);
    add(OP_FETCH, 4'd0,    8'h4D, 0, 1, 1, 4'b0000);
    add(OP_WR,    4'd1,    8'h81, 0, 1, 1, 4'b0000);
    add(OP_WR,    4'd3,    8'h81, 0, 1, 1, 4'b0000);
    add(OP_IRQ,   4'b1010, 8'h00, 0, 0, 0, 4'b0000);
    add(OP_INTA,  4'b0010, 8'h42, 1, 1, 0, 4'b0010);
    add(OP_INTA,  4'b0000, 8'h00, 0, 1, 0, 4'b0010);
    add(OP_FETCH, 4'd0,    8'hED, 0, 1, 0, 4'b0010);
    add(OP_FETCH, 4'd0,    8'h4D, 0, 0, 0, 4'b0000);
    add(OP_INTA,  4'b1000, 8'h46, 1, 1, 0, 4'b1000);
    add(OP_WR,    4'd0,    8'h81, 0, 1, 0, 4'b1000);
    add(OP_IRQ,   4'b0001, 8'h00, 0, 0, 0, 4'b1000);
    add(OP_INTA,  4'b0001, 8'h40, 1, 1, 0, 4'b1001);
    add(OP_FETCH, 4'd0,    8'hED, 0, 1, 0, 4'b1001);
    add(OP_FETCH, 4'd0,    8'h4D, 0, 1, 0, 4'b1000);
    add(OP_FETCH, 4'd0,    8'hED, 0, 1, 0, 4'b1000);
    add(OP_FETCH, 4'd0,    8'h4D, 0, 1, 1, 4'b0000);
    add(OP_IEI,   4'd0,    8'h00, 0, 1, 0, 4'b0000);
    add(OP_IRQ,   4'b0100, 8'h00, 0, 1, 0, 4'b0000);
    add(OP_INTA,  4'b0000, 8'h00, 0, 1, 0, 4'b0000);
    add(OP_IEI,   4'd1,    8'h00, 0, 0, 0, 4'b0000);
    add(OP_WR,    4'd2,    8'h83, 0, 1, 1, 4'b0000);
    add(OP_IRQ,   4'b0010, 8'h00, 0, 0, 0, 4'b0000);
    add(OP_INTA,  4'b0010, 8'h42, 1, 1, 0, 4'b0010);
    add(OP_FETCH, 4'd0,    8'hED, 0, 1, 0, 4'b0010);
    add(OP_FETCH, 4'd0,    8'h00, 0, 1, 0, 4'b0010);
    add(OP_FETCH, 4'd0,    8'h4D, 0, 1, 0, 4'b0010);
    add(OP_FETCH, 4'd0,    8'hED, 0, 1, 0, 4'b0010);
    add(OP_FETCH, 4'd0,    8'hED, 0, 1, 0, 4'b0010);
    add(OP_FETCH, 4'd0,    8'h4D, 0, 1, 1, 4'b0000);
    add(OP_WR,    4'd0,    8'hA0, 0, 1, 1, 4'b0000);
    add(OP_IRQ,   4'b1000, 8'h00, 0, 0, 0, 4'b0000);
    add(OP_INTA,  4'b1000, 8'hA6, 1, 1, 0, 4'b1000);
    add(OP_FETCH, 4'd0,    8'hED, 0, 1, 0, 4'b1000);
    add(OP_FETCH, 4'd0,    8'h4D, 0, 1, 1, 4'b0000);

    reset_n = 1'b0; ce_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1; iorq_n = 1'b1;
    a = 2'd0; din = 8'h00; irq = 4'b0000; iei = 1'b1;
    tick; tick; tick;
    chk("rst_int_n", 32'(int_n), 32'(1));
    chk("rst_ieo", 32'(ieo), 32'(0));
    chk("rst_vec_oe", 32'(vec_oe), 32'(0));
    chk("rst_vec", 32'(vec), 32'(0));
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_in_service", 32'(in_service), 32'(0));
    reset_n = 1'b1;
    tick;
    chk("ieo_after_release", 32'(ieo), 32'(1));

    for (int i = 0; i < steps.size(); i++) begin
      step_t s;
      s = steps[i];
      case (s.op)
        OP_WR:    bus_write(s.arg[1:0], s.data);
        OP_IRQ:   pulse_irq(s.arg);
        OP_INTA:  inta(s.ackv, s.data, s.arg, 4'b0000);
        OP_FETCH: fetch(s.data);
        OP_IEI:   iei = s.arg[0];
        default:  ;
      endcase
      tick; tick;
      chk($sformatf("step%0d_int_n", i), 32'(int_n), 32'(s.exp_int_n));
      chk($sformatf("step%0d_ieo", i), 32'(ieo), 32'(s.exp_ieo));
      chk($sformatf("step%0d_in_service", i), 32'(in_service), 32'(s.exp_isv));
    end

    // int_n latency: still high right after the sampling edge, low one cycle later.
    pulse_irq(4'b0001);
    chk("lat_int_n_t1", 32'(int_n), 32'(1));
    tick;
    chk("lat_int_n_t2", 32'(int_n), 32'(0));
    inta(1'b1, 8'hA0, 4'b0001, 4'b0000);
    fetch(8'hED); fetch(8'h4D); tick; tick;
    chk("lat_in_service", 32'(in_service), 32'(0));

    // A new request arriving on the acknowledge edge survives the acknowledge.
    pulse_irq(4'b0100); tick; tick;
    inta(1'b1, 8'hA4, 4'b0100, 4'b0100);
    tick;
    chk("setwin_in_service", 32'(in_service), 32'(4'b0100));
    chk("setwin_int_n_blocked", 32'(int_n), 32'(1));
    fetch(8'hED); fetch(8'h4D); tick; tick;
    chk("setwin_int_n_repend", 32'(int_n), 32'(0));
    inta(1'b1, 8'hA4, 4'b0100, 4'b0000);
    fetch(8'hED); fetch(8'h4D); tick; tick;
    chk("setwin_int_n_done", 32'(int_n), 32'(1));
    chk("setwin_ieo_done", 32'(ieo), 32'(1));

    // Reset asserted in the middle of an acknowledge cycle.
    pulse_irq(4'b1000); tick; tick;
    m1_n = 1'b0; iorq_n = 1'b0;
    tick;
    reset_n = 1'b0;
    #1;
    chk("midrst_vec_oe", 32'(vec_oe), 32'(0));
    chk("midrst_ack", 32'(ack), 32'(0));
    chk("midrst_vec", 32'(vec), 32'(0));
    chk("midrst_in_service", 32'(in_service), 32'(0));
    chk("midrst_int_n", 32'(int_n), 32'(1));
    m1_n = 1'b1; iorq_n = 1'b1;
    tick;
    reset_n = 1'b1;
    tick;
    chk("midrst_ieo_release", 32'(ieo), 32'(1));
    pulse_irq(4'b0001); tick; tick;
    chk("midrst_ie_cleared", 32'(int_n), 32'(1));

    chk("scoreboard_empty", 32'(sb_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
